// File: rtl/opcode_decoder_pipe.sv
// Two-stage registered opcode decoder: stage A captures the opcode, stage B
// produces a one-hot control vector with valid strobe and illegal-opcode tracking.
module opcode_decoder_pipe #(
    parameter int unsigned OP_W  = 4,
    parameter int unsigned N_OUT = 12,
    parameter int unsigned BASE  = 1,
    parameter int unsigned MODE  = 0,
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr_i,
    input  logic [OP_W-1:0]  in_i,
    input  logic             en_op_i,
    input  logic             en_out_i,
    output logic [N_OUT-1:0] out_o,
    output logic             out_valid_o,
    output logic             illegal_o,
    output logic [CNT_W-1:0] ill_cnt_o
);

    localparam int unsigned OP_SPAN   = 1 << OP_W;
    localparam int unsigned MODE_PULSE = 1;

    // Every one-hot output must correspond to a representable opcode.
    if (BASE + N_OUT > OP_SPAN) begin : g_range_chk
        $fatal(1, "opcode_decoder_pipe: BASE+N_OUT exceeds opcode range");
    end

    logic [OP_W-1:0]  op_q, op_d;
    logic             op_v_q, op_v_d;
    logic [N_OUT-1:0] out_q, out_d;
    logic             valid_q, valid_d;
    logic             ill_q, ill_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [31:0]      op_ext;
    logic [N_OUT-1:0] onehot;
    logic             legal;

    // Decode of the currently captured opcode; an out-of-range value yields all zeros.
    always_comb begin
        op_ext = 32'(op_q);
        onehot = '0;
        for (int unsigned k = 0; k < N_OUT; k++) begin
            onehot[k] = (op_ext == BASE + k);
        end
        legal = |onehot;
    end

    always_comb begin
        op_d    = op_q;
        op_v_d  = op_v_q;
        out_d   = (MODE == MODE_PULSE) ? '0 : out_q;
        valid_d = 1'b0;
        ill_d   = ill_q;
        cnt_d   = cnt_q;

        if (clr_i) begin
            op_d   = '0;
            op_v_d = 1'b0;
            out_d  = '0;
            ill_d  = 1'b0;
            cnt_d  = '0;
        end else begin
            if (en_op_i) begin
                op_d   = in_i;
                op_v_d = 1'b1;
            end
            // Stage B consumes the pre-edge opcode, so same-edge captures decode later.
            if (en_out_i && op_v_q) begin
                valid_d = 1'b1;
                out_d   = onehot;
                ill_d   = ~legal;
                if (!legal && (cnt_q != {CNT_W{1'b1}})) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q    <= '0;
            op_v_q  <= 1'b0;
            out_q   <= '0;
            valid_q <= 1'b0;
            ill_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            op_q    <= op_d;
            op_v_q  <= op_v_d;
            out_q   <= out_d;
            valid_q <= valid_d;
            ill_q   <= ill_d;
            cnt_q   <= cnt_d;
        end
    end

    assign out_o       = out_q;
    assign out_valid_o = valid_q;
    assign illegal_o   = ill_q;
    assign ill_cnt_o   = cnt_q;

endmodule

// File: tb/tb_opcode_decoder_pipe.sv
// Bench for opcode_decoder_pipe: HOLD, PULSE and 2-bit-counter instances share
// one stimulus stream and are compared against an abstract decode model.
module tb_opcode_decoder_pipe;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       clr;
    logic [3:0] in_op;
    logic       en_op;
    logic       en_out;

    logic [11:0] out_h, out_p, out_s;
    logic        vld_h, vld_p, vld_s;
    logic        ill_h, ill_p, ill_s;
    logic [7:0]  cnt_h, cnt_p;
    logic [1:0]  cnt_s;

    int checks = 0;
    int errors = 0;

    // Reference state: captured opcode plus per-instance outputs (0=HOLD, 1=PULSE, 2=sat2).
    int          m_op;
    bit          m_opv;
    bit          m_valid;
    logic [11:0] m_out [3];
    bit          m_ill [3];
    int          m_cnt [3];
    int          m_max [3] = '{255, 255, 3};

    always #5 clk = ~clk;

    opcode_decoder_pipe #(.OP_W(4), .N_OUT(12), .BASE(1), .MODE(0), .CNT_W(8)) dut_h (
        .clk(clk), .rst_n(rst_n), .clr_i(clr), .in_i(in_op), .en_op_i(en_op),
        .en_out_i(en_out), .out_o(out_h), .out_valid_o(vld_h), .illegal_o(ill_h),
        .ill_cnt_o(cnt_h));

    opcode_decoder_pipe #(.OP_W(4), .N_OUT(12), .BASE(1), .MODE(1), .CNT_W(8)) dut_p (
        .clk(clk), .rst_n(rst_n), .clr_i(clr), .in_i(in_op), .en_op_i(en_op),
        .en_out_i(en_out), .out_o(out_p), .out_valid_o(vld_p), .illegal_o(ill_p),
        .ill_cnt_o(cnt_p));

    opcode_decoder_pipe #(.OP_W(4), .N_OUT(12), .BASE(1), .MODE(0), .CNT_W(2)) dut_s (
        .clk(clk), .rst_n(rst_n), .clr_i(clr), .in_i(in_op), .en_op_i(en_op),
        .en_out_i(en_out), .out_o(out_s), .out_valid_o(vld_s), .illegal_o(ill_s),
        .ill_cnt_o(cnt_s));

    task automatic cmp(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_op    = 0;
        m_opv   = 1'b0;
        m_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            m_out[i] = '0;
            m_ill[i] = 1'b0;
            m_cnt[i] = 0;
        end
    endtask

    // Opcode k in 1..12 selects output bit k-1; anything else is illegal.
    task automatic model_edge(input bit c, input bit eo, input bit eu, input int v);
        bit fire;
        bit ok;
        if (c) begin
            model_reset();
        end else begin
            fire = eu && m_opv;
            ok   = (m_op >= 1) && (m_op <= 12);
            for (int i = 0; i < 3; i++) begin
                if (fire) begin
                    m_out[i] = ok ? 12'(1 << (m_op - 1)) : 12'h000;
                    m_ill[i] = !ok;
                    if (!ok && m_cnt[i] < m_max[i]) m_cnt[i] = m_cnt[i] + 1;
                end else if (i == 1) begin
                    m_out[i] = 12'h000;
                end
            end
            m_valid = fire;
            if (eo) begin
                m_op  = v;
                m_opv = 1'b1;
            end
        end
    endtask

    task automatic check_all(input string tag);
        cmp({tag, ".out_h"}, 32'(out_h), 32'(m_out[0]));
        cmp({tag, ".out_p"}, 32'(out_p), 32'(m_out[1]));
        cmp({tag, ".out_s"}, 32'(out_s), 32'(m_out[2]));
        cmp({tag, ".vld_h"}, 32'(vld_h), 32'(m_valid));
        cmp({tag, ".vld_p"}, 32'(vld_p), 32'(m_valid));
        cmp({tag, ".vld_s"}, 32'(vld_s), 32'(m_valid));
        cmp({tag, ".ill_h"}, 32'(ill_h), 32'(m_ill[0]));
        cmp({tag, ".ill_p"}, 32'(ill_p), 32'(m_ill[1]));
        cmp({tag, ".ill_s"}, 32'(ill_s), 32'(m_ill[2]));
        cmp({tag, ".cnt_h"}, 32'(cnt_h), 32'(m_cnt[0]));
        cmp({tag, ".cnt_p"}, 32'(cnt_p), 32'(m_cnt[1]));
        cmp({tag, ".cnt_s"}, 32'(cnt_s), 32'(m_cnt[2]));
        cmp({tag, ".onehot_p"}, 32'($onehot0(out_p)), 32'd1);
    endtask

    // Drive inputs between edges, clock once, then compare just after the edge.
    task automatic step(input string tag, input bit c, input bit eo, input bit eu, input int v);
        clr    = c;
        en_op  = eo;
        en_out = eu;
        in_op  = 4'(v);
        @(posedge clk);
        model_edge(c, eo, eu, v);
        #1;
        check_all(tag);
    endtask

    initial begin
        rst_n  = 1'b0;
        clr    = 1'b0;
        in_op  = '0;
        en_op  = 1'b0;
        en_out = 1'b0;
        model_reset();
        #12;
        check_all("reset");
        rst_n = 1'b1;

        // Single capture then decode of opcode 1.
        step("cap1", 0, 1, 0, 1);
        step("dec1", 0, 0, 1, 0);
        cmp("dec1.out_lit", 32'(out_h), 32'h001);
        step("idle1", 0, 0, 0, 0);

        // Back-to-back sweep with both enables high, then drop enables.
        for (int v = 1; v <= 12; v++) step("sweep", 0, 1, 1, v);
        step("sweep_tail", 0, 0, 1, 0);
        step("sweep_hold", 0, 0, 0, 0);
        step("sweep_hold2", 0, 0, 0, 0);
        cmp("sweep.out_lit", 32'(out_h), 32'h800);

        // Illegal opcodes, then a legal one.
        for (int i = 0; i < 4; i++) begin
            step("ill_cap", 0, 1, 0, (i == 0) ? 0 : 12 + i);
            step("ill_dec", 0, 0, 1, 0);
        end
        cmp("ill.cnt_lit", 32'(cnt_h), 32'd4);
        cmp("ill.sat_lit", 32'(cnt_s), 32'd3);
        step("leg_cap", 0, 1, 0, 5);
        step("leg_dec", 0, 0, 1, 0);
        cmp("leg.out_lit", 32'(out_h), 32'h010);
        step("ill5_cap", 0, 1, 0, 15);
        step("ill5_dec", 0, 0, 1, 0);

        // Synchronous clear, then an orphan EN_OUT produces nothing.
        step("clr", 1, 1, 1, 3);
        step("post_clr", 0, 0, 1, 0);

        // PULSE instance: one cycle of 0x004.
        step("p_cap", 0, 1, 0, 3);
        step("p_dec", 0, 0, 1, 0);
        cmp("p.out_lit", 32'(out_p), 32'h004);
        step("p_after", 0, 0, 0, 0);

        // Asynchronous reset between edges while OUT=0x040.
        step("r_cap", 0, 1, 0, 7);
        step("r_dec", 0, 0, 1, 0);
        cmp("r.out_lit", 32'(out_h), 32'h040);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all("async_rst");
        #1;
        rst_n = 1'b1;
        step("r_orphan", 0, 0, 1, 0);

        // Randomized traffic.
        for (int n = 0; n < 400; n++) begin
            step("rand", ($urandom_range(0, 31) == 0), 1'($urandom), 1'($urandom),
                 int'($urandom_range(0, 15)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/opcode_decoder_pipe.md
Name: opcode_decoder_pipe

Overview:
- Registered, parametrised successor to the processor's opcode-to-one-hot control decoder.
- Captures an opcode into a stage-A register, then decodes it into a one-hot control-line vector in a stage-B output register.
- Adds the following over the combinational decoder: defined reset values, a valid strobe, illegal-opcode detection with a saturating error counter, and selectable hold/pulse output mode.
- Sits between the instruction register and the datapath control inputs.

Parameters:
- OP_W, 4, opcode width in bits.
- N_OUT, 12, number of one-hot control outputs.
- BASE, 1, opcode value that maps to OUT[0]; opcode BASE+k maps to OUT[k].
- MODE, 0, 0 = HOLD (OUT keeps its last decode), 1 = PULSE (OUT is asserted for one cycle per decode).
- CNT_W, 8, width of the illegal-decode counter.

Ports:
- CLK  in  1  rising-edge clock.
- RST_N  in  1  asynchronous active-low reset.
- CLR  in  1  synchronous clear of the pipeline state and ILL_CNT.
- IN  in  OP_W  opcode input.
- EN_OP  in  1  capture strobe for stage A.
- EN_OUT  in  1  decode/update strobe for stage B.
- OUT  out  N_OUT  registered one-hot control vector.
- OUT_VALID  out  1  one-cycle pulse; OUT/ILLEGAL were updated this cycle.
- ILLEGAL  out  1  registered flag; the last decode was out of range.
- ILL_CNT  out  CNT_W  saturating count of illegal decodes.

Behaviour:
- One clock. Reset is asynchronous and active-low.
- Reset (RST_N=0, asynchronous) sets: OP_Q=0, OP_V=0, OUT=0, OUT_VALID=0, ILLEGAL=0, ILL_CNT=0.
- Elaboration check: BASE+N_OUT <= 2**OP_W; otherwise a fatal error.
- CLR=1 at a clock edge has the same effect as reset, takes priority over EN_OP/EN_OUT, and is effective next cycle.
- Stage A: at an edge with EN_OP=1, OP_Q<=IN and OP_V<=1. With EN_OP=0, OP_Q and OP_V hold. OP_V clears only on reset or CLR.
- Stage B fires at an edge with EN_OUT=1 and OP_V=1, and always uses the pre-edge OP_Q:
  - Legal decode (OP_Q>=BASE and OP_Q-BASE<N_OUT): OUT<=one-hot bit (OP_Q-BASE), ILLEGAL<=0.
  - Illegal decode (otherwise, including OP_Q=0 when BASE=1): OUT<=0, ILLEGAL<=1, ILL_CNT<=ILL_CNT+1, saturating at 2**CNT_W-1.
  - OUT_VALID<=1 for exactly that cycle.
- Stage B does not fire when EN_OUT=1 and OP_V=0: OUT, ILLEGAL and ILL_CNT hold, and OUT_VALID=0.
- When stage B does not fire:
  - OUT_VALID<=0.
  - HOLD mode: OUT and ILLEGAL hold.
  - PULSE mode: OUT<=0 and ILLEGAL holds.
- Latency:
  - IN to OUT is 2 edges: EN_OP at edge n, EN_OUT at edge n+1.
  - EN_OP and EN_OUT at the same edge decode the previously captured opcode; the new opcode is decoded at the next EN_OUT.
- Back-to-back: with both enables held high, OUT tracks IN delayed by 2 cycles, one decode per cycle. In PULSE mode OUT stays asserted while decodes continue.
- Invariant: OUT is always either zero or one-hot. It is never multi-hot.
- Reset asserted mid-stream clears everything immediately, with no edge needed. After release, the first EN_OUT before any EN_OP produces no update.

Test Plan:
- Reset, then EN_OP=1 with IN=4'b0001, then EN_OUT=1 the next cycle -> OUT=12'h001, OUT_VALID pulses once, ILLEGAL=0.
- Sweep IN=1..12 with both enables held high (HOLD) -> OUT=1<<(IN-1) two cycles after each IN; after both enables drop, OUT holds 12'h800.
- IN=0, then IN=13, 14, 15, each captured and decoded -> OUT=0, ILLEGAL=1, ILL_CNT=4. Then IN=5 -> OUT=12'h010, ILLEGAL=0, ILL_CNT stays 4.
- CNT_W=2 with 5 illegal decodes -> ILL_CNT saturates at 3. Then CLR=1 for one cycle -> ILL_CNT=0, OUT=0, OP_V=0, and a following EN_OUT alone gives no OUT_VALID.
- MODE=1: capture IN=3, single EN_OUT pulse -> OUT=12'h004 for exactly one cycle, then 0; OUT_VALID coincident.
- Drive RST_N low asynchronously between edges while OUT=12'h040 -> OUT=0 and ILLEGAL=0 before the next edge; EN_OUT right after release gives no update.
